// File: rtl/fma_mac_pipe.sv
// Three-stage pipelined multiply-accumulate: out = a*b + (c | acc), signed or unsigned per beat.
// S1 captures operands, S2 holds the extended product, S3 adds, updates acc and drives out/ovf.
module fma_mac_pipe #(
   parameter int W     = 32,
   parameter int ACC_W = 72
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [ACC_W-1:0] c,
   input  logic             signed_mode,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out,
   output logic             ovf
);

   // Handshake: a beat moves on in_valid & in_ready, a result on out_valid & out_ready.
   // A result held without out_ready freezes every stage, so in_ready drops in the same cycle.
   logic stall;

   logic             s1_valid_q;
   logic [W-1:0]     s1_a_q;
   logic [W-1:0]     s1_b_q;
   logic [ACC_W-1:0] s1_c_q;
   logic             s1_signed_q;
   logic             s1_acc_en_q;
   logic             s1_acc_clr_q;

   logic             s2_valid_q;
   logic [ACC_W-1:0] s2_prod_q;
   logic [ACC_W-1:0] s2_c_q;
   logic             s2_signed_q;
   logic             s2_acc_en_q;
   logic             s2_acc_clr_q;

   logic             out_valid_q;
   logic [ACC_W-1:0] out_q;
   logic             ovf_q;
   logic [ACC_W-1:0] acc_q;

   logic [2*W-1:0]   a_x;
   logic [2*W-1:0]   b_x;
   logic [2*W-1:0]   prod_full;
   logic [ACC_W-1:0] prod_d;

   logic [ACC_W-1:0] addend;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] out_d;
   logic             ovf_d;
   logic [ACC_W-1:0] acc_d;

   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign ovf       = ovf_q;

   // Extending both operands to 2W bits lets one multiplier serve both modes.
   always_comb begin
      a_x       = {{W{s1_signed_q & s1_a_q[W-1]}}, s1_a_q};
      b_x       = {{W{s1_signed_q & s1_b_q[W-1]}}, s1_b_q};
      prod_full = a_x * b_x;
      if (s1_signed_q) begin
         prod_d = ACC_W'($signed(prod_full));
      end else begin
         prod_d = ACC_W'(prod_full);
      end
   end

   always_comb begin
      addend = s2_c_q;
      if (s2_acc_en_q) begin
         addend = s2_acc_clr_q ? '0 : acc_q;
      end
      sum   = {1'b0, addend} + {1'b0, s2_prod_q};
      out_d = sum[ACC_W-1:0];
      if (s2_signed_q) begin
         ovf_d = (addend[ACC_W-1] == s2_prod_q[ACC_W-1]) &&
                 (out_d[ACC_W-1] != addend[ACC_W-1]);
      end else begin
         ovf_d = sum[ACC_W];
      end
      acc_d = acc_q;
      if (s2_acc_en_q) begin
         acc_d = out_d;
      end else if (s2_acc_clr_q) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_c_q       <= '0;
         s1_signed_q  <= 1'b0;
         s1_acc_en_q  <= 1'b0;
         s1_acc_clr_q <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_prod_q    <= '0;
         s2_c_q       <= '0;
         s2_signed_q  <= 1'b0;
         s2_acc_en_q  <= 1'b0;
         s2_acc_clr_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         ovf_q        <= 1'b0;
         acc_q        <= '0;
      end else if (!stall) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_a_q       <= a;
            s1_b_q       <= b;
            s1_c_q       <= c;
            s1_signed_q  <= signed_mode;
            s1_acc_en_q  <= acc_en;
            s1_acc_clr_q <= acc_clr;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_prod_q    <= prod_d;
            s2_c_q       <= s1_c_q;
            s2_signed_q  <= s1_signed_q;
            s2_acc_en_q  <= s1_acc_en_q;
            s2_acc_clr_q <= s1_acc_clr_q;
         end
         // Bubbles leave out/ovf/acc untouched so the last result stays visible.
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            acc_q <= acc_d;
         end
      end
   end

endmodule

// File: tb/tb_fma_mac_pipe.sv
// Bench for fma_mac_pipe: directed vector table, latency/backpressure/reset sequences,
// then random traffic scored against a wide-integer arithmetic model.
module tb_fma_mac_pipe;
  localparam int W     = 32;
  localparam int ACC_W = 72;

  typedef logic signed [191:0] big_t;
  localparam big_t SMAX = (big_t'(1) <<< (ACC_W-1)) - big_t'(1);
  localparam big_t SMIN = -(big_t'(1) <<< (ACC_W-1));
  localparam big_t UMAX = (big_t'(1) <<< ACC_W) - big_t'(1);

  typedef struct {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [ACC_W-1:0] c;
    logic             mode;
    logic             en;
    logic             clr;
    logic [ACC_W-1:0] exp_out;
    logic             exp_ovf;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [ACC_W-1:0] c;
  logic             signed_mode;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic [ACC_W:0]   exp_q[$];
  logic [ACC_W-1:0] acc_m;
  logic             tbl_active;
  logic [ACC_W:0]   tbl_exp;
  logic             rand_ready;
  vec_t             tbl[17];

  fma_mac_pipe #(.W(W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .c           (c),
    .signed_mode (signed_mode),
    .acc_en      (acc_en),
    .acc_clr     (acc_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .ovf         (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [ACC_W:0] act, input logic [ACC_W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference model: exact integer arithmetic, then wrap and range test
  function automatic logic [ACC_W:0] model_step(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                                input logic [ACC_W-1:0] mc, input logic mm,
                                                input logic me, input logic mcl);
    big_t av, bv, addv, tot;
    logic [ACC_W-1:0] add, res;
    logic ov;
    add = me ? (mcl ? '0 : acc_m) : mc;
    if (mm) begin
      av   = big_t'($signed(ma));
      bv   = big_t'($signed(mb));
      addv = big_t'($signed(add));
    end else begin
      av   = big_t'(ma);
      bv   = big_t'(mb);
      addv = big_t'(add);
    end
    tot = av * bv + addv;
    res = tot[ACC_W-1:0];
    if (mm) ov = (tot > SMAX) || (tot < SMIN);
    else    ov = (tot > UMAX);
    if (me)       acc_m = res;
    else if (mcl) acc_m = '0;
    return {ov, res};
  endfunction

  // scoreboard: push at acceptance, pop at transfer
  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) begin
        logic [ACC_W:0] r;
        r = model_step(a, b, c, signed_mode, acc_en, acc_clr);
        exp_q.push_back(tbl_active ? tbl_exp : r);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h required=none", {ovf, out});
        end else begin
          chk("result", {ovf, out}, exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
  end

  // driver tasks (caller sits at posedge+1 on entry and exit)
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic [ACC_W-1:0] tc,
                      input logic tm, input logic te, input logic tcl);
    logic ok;
    ok          = 1'b0;
    a           = ta;
    b           = tb2;
    c           = tc;
    signed_mode = tm;
    acc_en      = te;
    acc_clr     = tcl;
    in_valid    = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    chk("accept", {{ACC_W{1'b0}}, ok}, {{ACC_W{1'b0}}, 1'b1});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", (ACC_W+1)'(exp_q.size()), '0);
  endtask

  function automatic logic [W-1:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(32'h8000_0000);
      3:       return W'(32'h7FFF_FFFF);
      default: return W'($urandom());
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] pick_c();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(ACC_W-1){1'b1}}};
      3:       return {1'b1, {(ACC_W-1){1'b0}}};
      default: return ACC_W'({$urandom(), $urandom(), $urandom()});
    endcase
  endfunction

  initial begin
    tbl[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 72'd1, 1'b0, 1'b0, 1'b0, 72'h00_FFFF_FFFE_0000_0002, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'd5, 72'd10, 1'b1, 1'b0, 1'b0, 72'd5, 1'b0};
    tbl[2]  = '{32'd1, 32'd1, 72'h7F_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 72'h80_0000_0000_0000_0000, 1'b1};
    tbl[3]  = '{32'd1, 32'd1, 72'hFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 72'd0, 1'b1};
    tbl[4]  = '{32'd1, 32'd3, 72'd0, 1'b0, 1'b1, 1'b1, 72'd3, 1'b0};
    tbl[5]  = '{32'd2, 32'd3, 72'd0, 1'b0, 1'b1, 1'b0, 72'd9, 1'b0};
    tbl[6]  = '{32'd3, 32'd3, 72'd0, 1'b0, 1'b1, 1'b0, 72'd18, 1'b0};
    tbl[7]  = '{32'd4, 32'd3, 72'd0, 1'b0, 1'b1, 1'b0, 72'd30, 1'b0};
    tbl[8]  = '{32'd2, 32'd2, 72'd100, 1'b0, 1'b0, 1'b0, 72'd104, 1'b0};
    tbl[9]  = '{32'd1, 32'd1, 72'd0, 1'b0, 1'b1, 1'b0, 72'd31, 1'b0};
    tbl[10] = '{32'hFFFF_FFFD, 32'd4, 72'd0, 1'b1, 1'b1, 1'b1, 72'hFF_FFFF_FFFF_FFFF_FFF4, 1'b0};
    tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 72'd0, 1'b1, 1'b1, 1'b0, 72'hFF_FFFF_FFFF_FFFF_FFF5, 1'b0};
    tbl[12] = '{32'h8000_0000, 32'd2, 72'd0, 1'b0, 1'b0, 1'b0, 72'h1_0000_0000, 1'b0};
    tbl[13] = '{32'h8000_0000, 32'h8000_0000, 72'd0, 1'b1, 1'b0, 1'b0, 72'h00_4000_0000_0000_0000, 1'b0};
    tbl[14] = '{32'hFFFF_FFFF, 32'd1, 72'h80_0000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 72'h7F_FFFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[15] = '{32'd0, 32'd0, 72'd7, 1'b0, 1'b0, 1'b1, 72'd7, 1'b0};
    tbl[16] = '{32'd2, 32'd3, 72'd0, 1'b0, 1'b1, 1'b0, 72'd6, 1'b0};

    rst         = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    c           = '0;
    signed_mode = 1'b0;
    acc_en      = 1'b0;
    acc_clr     = 1'b0;
    acc_m       = '0;
    tbl_active  = 1'b0;
    tbl_exp     = '0;
    rand_ready  = 1'b0;

    #12;
    chk("reset_out_valid", {{ACC_W{1'b0}}, out_valid}, '0);
    chk("reset_out", {1'b0, out}, '0);
    chk("reset_ovf", {{ACC_W{1'b0}}, ovf}, '0);
    chk("reset_in_ready", {{ACC_W{1'b0}}, in_ready}, {{ACC_W{1'b0}}, 1'b1});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // directed table, back-to-back beats
    tbl_active = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tbl_exp = {tbl[i].exp_ovf, tbl[i].exp_out};
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].mode, tbl[i].en, tbl[i].clr);
    end
    tbl_active = 1'b0;
    drain();

    // exact latency
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 72'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat1_valid", {{ACC_W{1'b0}}, out_valid}, '0);
    @(negedge clk);
    chk("lat2_valid", {{ACC_W{1'b0}}, out_valid}, '0);
    @(negedge clk);
    chk("lat3_valid", {{ACC_W{1'b0}}, out_valid}, {{ACC_W{1'b0}}, 1'b1});
    chk("lat3_out", {ovf, out}, {1'b0, 72'h00_FFFF_FFFE_0000_0002});
    @(posedge clk);
    #1;
    drain();

    // backpressure
    out_ready = 1'b0;
    send(32'd3, 32'd7, 72'd1, 1'b0, 1'b0, 1'b0);
    send(32'd5, 32'd5, 72'd0, 1'b0, 1'b0, 1'b0);
    send(32'd100, 32'd100, 72'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {{ACC_W{1'b0}}, in_ready}, '0);
      chk("stall_valid", {{ACC_W{1'b0}}, out_valid}, {{ACC_W{1'b0}}, 1'b1});
      chk("stall_out_held", {ovf, out}, {1'b0, 72'd22});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_r0", {out_valid, out}, {1'b1, 72'd22});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_r1", {out_valid, out}, {1'b1, 72'd25});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_r2", {out_valid, out}, {1'b1, 72'd10007});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_no_dup", {{ACC_W{1'b0}}, out_valid}, '0);
    chk("idle_out_hold", {1'b0, out}, {1'b0, 72'd10007});
    @(posedge clk);
    #1;
    drain();

    // reset with beats in flight
    send(32'd9, 32'd9, 72'd0, 1'b0, 1'b0, 1'b0);
    send(32'd4, 32'd4, 72'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {{ACC_W{1'b0}}, out_valid}, '0);
    chk("midrst_out", {ovf, out}, '0);
    exp_q.delete();
    acc_m = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {{ACC_W{1'b0}}, out_valid}, '0);
      @(posedge clk);
      #1;
    end
    send(32'd2, 32'd3, 72'd0, 1'b0, 1'b1, 1'b0);
    drain();

    // random traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pick_op(), pick_op(), pick_c(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
